vc_test_check_sink: RTL and testbench

VC_TEST_CHECK_SINK -- requirements
Module: vc_test_check_sink

---
 rtl/vc_test_pkg.sv | 14 +
 rtl/vc_test_delay_ctr.sv | 38 +++
 rtl/vc_test_check_sink.sv | 158 +++++++++++++++
 tb/tb_vc_test_check_sink.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_test_pkg.sv
// Shared types for the test check sink.
// Holds the sink FSM states and the error counter width.
package vc_test_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_READY,
        ST_DELAY,
        ST_DONE
    } state_e;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/vc_test_delay_ctr.sv
// Down-counter that times the idle gap after each accepted message.
// The counter loads, decrements to zero and holds there.
module vc_test_delay_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load takes priority; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/vc_test_check_sink.sv
// Test sink: compares incoming messages against a loaded store.
// Reports done, sticky error, mismatch count and first bad index.
module vc_test_check_sink
    import vc_test_pkg::*;
#(
    parameter  int p_msg_nbits = 8,
    parameter  int p_num_msgs  = 16,
    localparam int IW          = $clog2(p_num_msgs),
    localparam int CW          = $clog2(p_num_msgs + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            delay_amt,
    input  logic                   load_en,
    input  logic [IW-1:0]          load_addr,
    input  logic [p_msg_nbits-1:0] load_msg,
    input  logic [CW-1:0]          num_expected,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    output logic                   done,
    output logic                   error,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic [IW-1:0]          err_idx,
    input  logic                   test_cnt_ld,
    input  logic [ERR_CNT_W-1:0]   test_cnt_val
);

    state_e                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CW-1:0]          nexp_q, nexp_d;
    logic                   err_q, err_d;
    logic [ERR_CNT_W-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]          eidx_q, eidx_d;
    logic                   mis_q, mis_d;
    logic [p_msg_nbits-1:0] mem_q [p_num_msgs];

    logic                   xfer;
    logic                   mismatch;
    logic [CW-1:0]          idx_nx;
    logic                   ctr_load;
    logic                   ctr_dec;
    logic                   ctr_zero;
    logic [31:0]            ctr_val;

    assign in_rdy   = (state_q == ST_READY);
    assign done     = (state_q == ST_DONE);
    assign xfer     = in_val && in_rdy;
    assign mismatch = xfer && (in_msg != mem_q[idx_q]);
    assign idx_nx   = CW'(idx_q) + CW'(1);
    assign ctr_val  = delay_amt - 32'd1;

    vc_test_delay_ctr #(
        .W(32)
    ) u_ctr (
        .clk     (clk),
        .reset   (reset),
        .load    (ctr_load),
        .load_val(ctr_val),
        .dec     (ctr_dec),
        .zero    (ctr_zero)
    );

    // Next-state, compare and error bookkeeping.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        nexp_d   = nexp_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        eidx_d   = eidx_q;
        mis_d    = mis_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                nexp_d  = num_expected;
                state_d = (num_expected == '0) ? ST_DONE : ST_READY;
            end
            ST_READY: begin
                if (in_val) begin
                    idx_d = idx_q + IW'(1);
                    if (idx_nx == nexp_q) begin
                        state_d = ST_DONE;
                    end else if (delay_amt == 32'd0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d  = ST_DELAY;
                        ctr_load = 1'b1;
                    end
                end
            end
            ST_DELAY: begin
                ctr_dec = 1'b1;
                if (ctr_zero) begin
                    state_d = ST_READY;
                end
            end
            ST_DONE: begin
                if (in_val) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
        if (mismatch) begin
            err_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end
            if (!mis_q) begin
                eidx_d = idx_q;
                mis_d  = 1'b1;
            end
        end
        if (test_cnt_ld) begin
            cnt_d = test_cnt_val;
        end
    end

    // Control and status registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            nexp_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            eidx_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            nexp_q  <= nexp_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            eidx_q  <= eidx_d;
            mis_q   <= mis_d;
        end
    end

    // Expected-message store; survives reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_msg;
        end
    end

    assign error     = err_q;
    assign err_count = cnt_q;
    assign err_idx   = eidx_q;

`ifndef SYNTHESIS
    chk_no_x: assert property (@(posedge clk) disable iff (!reset)
        !$isunknown({in_val, delay_amt}));
`endif

endmodule

// File: tb/tb_vc_test_check_sink.sv
// Bench for vc_test_check_sink.
// Table of end-to-end runs plus directed corner-case sequences.
module tb_vc_test_check_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] delay_amt;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [7:0]  load_msg;
    logic [4:0]  num_expected;
    logic        in_val;
    logic        in_rdy;
    logic [7:0]  in_msg;
    logic        done;
    logic        error;
    logic [15:0] err_count;
    logic [3:0]  err_idx;
    logic        test_cnt_ld;
    logic [15:0] test_cnt_val;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    vc_test_check_sink dut (
        .clk         (clk),
        .reset       (reset),
        .delay_amt   (delay_amt),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_msg    (load_msg),
        .num_expected(num_expected),
        .in_val      (in_val),
        .in_rdy      (in_rdy),
        .in_msg      (in_msg),
        .done        (done),
        .error       (error),
        .err_count   (err_count),
        .err_idx     (err_idx),
        .test_cnt_ld (test_cnt_ld),
        .test_cnt_val(test_cnt_val)
    );

    typedef struct {
        logic [31:0] m;
        int          n;
        int          dly;
        logic        e;
        logic [15:0] c;
        logic [3:0]  ix;
        int          cyc;
    } vec_t;

    vec_t vt [6];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(bit load);
        reset       = 1'b0;
        in_val      = 1'b0;
        in_msg      = 8'h00;
        load_en     = 1'b0;
        test_cnt_ld = 1'b0;
        delay_amt   = 32'd0;
        #1;
        if (load) begin
            for (int i = 0; i < 4; i++) begin
                load_en   = 1'b1;
                load_addr = 4'(i);
                load_msg  = 8'((i + 1) * 17);
                tick();
            end
            load_en = 1'b0;
        end
        tick();
    endtask

    task automatic start(int n);
        num_expected = 5'(n);
        reset        = 1'b1;
        tick();
    endtask

    task automatic run_vec(int k, bit load);
        vec_t v;
        int   cyc;
        int   gap;
        int   xf;
        bit   gap_ok;
        bit   rdy;
        v      = vt[k];
        cyc    = 0;
        gap    = 0;
        xf     = 0;
        gap_ok = 1'b1;
        do_reset(load);
        start(v.n);
        in_val = 1'b1;
        while (xf < v.n && cyc < 200) begin
            rdy       = in_rdy;
            delay_amt = rdy ? 32'(v.dly) : 32'd7;
            in_msg    = v.m[8*xf +: 8];
            if (rdy && xf > 0 && gap != v.dly) gap_ok = 1'b0;
            tick();
            cyc++;
            if (rdy) begin
                xf++;
                gap = 0;
            end else begin
                gap++;
            end
        end
        in_val = 1'b0;
        chk($sformatf("v%0d_cycles", k), 32'(cyc), 32'(v.cyc));
        chk($sformatf("v%0d_gap", k), 32'(gap_ok), 32'd1);
        chk($sformatf("v%0d_done", k), 32'(done), 32'd1);
        chk($sformatf("v%0d_error", k), 32'(error), 32'(v.e));
        chk($sformatf("v%0d_errcnt", k), 32'(err_count), 32'(v.c));
        chk($sformatf("v%0d_erridx", k), 32'(err_idx), 32'(v.ix));
    endtask

    initial begin
        bit seen;

        vt[0] = '{32'h44332211, 4, 0, 1'b0, 16'd0, 4'd0, 4};
        vt[1] = '{32'h44332211, 4, 3, 1'b0, 16'd0, 4'd0, 13};
        vt[2] = '{32'h00339911, 4, 0, 1'b1, 16'd2, 4'd1, 4};
        vt[3] = '{32'h55332211, 4, 1, 1'b1, 16'd1, 4'd3, 7};
        vt[4] = '{32'h00002211, 2, 2, 1'b0, 16'd0, 4'd0, 4};
        vt[5] = '{32'h00000000, 4, 0, 1'b1, 16'd4, 4'd0, 4};

        test_cnt_val = 16'h0;
        num_expected = 5'd0;
        load_addr    = 4'd0;
        load_msg     = 8'h00;
        do_reset(1'b0);
        chk("rst_rdy", 32'(in_rdy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_errcnt", 32'(err_count), 32'd0);
        chk("rst_erridx", 32'(err_idx), 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_vec(k, 1'b1);
        end

        // zero expected messages, then overflow
        do_reset(1'b1);
        start(0);
        chk("z_done", 32'(done), 32'd1);
        chk("z_rdy", 32'(in_rdy), 32'd0);
        seen   = 1'b0;
        in_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (in_rdy) seen = 1'b1;
        end
        in_val = 1'b0;
        chk("z_rdy_seen", 32'(seen), 32'd0);
        chk("z_error", 32'(error), 32'd1);
        chk("z_errcnt", 32'(err_count), 32'd0);

        // reset during DELAY after two transfers
        do_reset(1'b1);
        start(4);
        in_val    = 1'b1;
        delay_amt = 32'd3;
        in_msg    = 8'h11;
        tick();
        in_msg = 8'h98;
        for (int i = 0; i < 3; i++) tick();
        chk("b_rdy_back", 32'(in_rdy), 32'd1);
        tick();
        chk("b_error", 32'(error), 32'd1);
        chk("b_rdy_delay", 32'(in_rdy), 32'd0);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("b_rst_rdy", 32'(in_rdy), 32'd0);
        chk("b_rst_error", 32'(error), 32'd0);
        chk("b_rst_errcnt", 32'(err_count), 32'd0);
        chk("b_rst_erridx", 32'(err_idx), 32'd0);
        chk("b_rst_done", 32'(done), 32'd0);
        run_vec(0, 1'b0);

        // store write to the index under compare
        do_reset(1'b1);
        start(2);
        delay_amt = 32'd0;
        in_val    = 1'b1;
        in_msg    = 8'h11;
        load_en   = 1'b1;
        load_addr = 4'd0;
        load_msg  = 8'h77;
        tick();
        in_val    = 1'b0;
        load_addr = 4'd1;
        load_msg  = 8'h5A;
        tick();
        load_en = 1'b0;
        in_val  = 1'b1;
        in_msg  = 8'h5A;
        tick();
        in_val = 1'b0;
        chk("c_done", 32'(done), 32'd1);
        chk("c_error", 32'(error), 32'd0);

        // counter saturation over 16 + 4 mismatches
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            load_en   = 1'b1;
            load_addr = 4'(i);
            load_msg  = 8'(i);
            tick();
        end
        load_en = 1'b0;
        start(16);
        test_cnt_ld  = 1'b1;
        test_cnt_val = 16'hFFF0;
        tick();
        test_cnt_ld = 1'b0;
        chk("d_preload", 32'(err_count), 32'hFFF0);
        in_val    = 1'b1;
        in_msg    = 8'hFF;
        delay_amt = 32'd0;
        for (int i = 0; i < 16; i++) tick();
        in_val = 1'b0;
        chk("d_done", 32'(done), 32'd1);
        chk("d_sat", 32'(err_count), 32'hFFFF);
        chk("d_erridx", 32'(err_idx), 32'd0);
        do_reset(1'b0);
        start(4);
        test_cnt_ld  = 1'b1;
        test_cnt_val = 16'hFFFE;
        tick();
        test_cnt_ld = 1'b0;
        in_val      = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        in_val = 1'b0;
        chk("d2_done", 32'(done), 32'd1);
        chk("d2_sat", 32'(err_count), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
